// File: rtl/hazard_ctrl_pkg.sv
// Shared MIPS pipeline definitions: forwarding selects, mul/div FSM states,
// and the forwarding-priority helper used by the hazard controller.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Memory stage has the newer value, so it wins over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       rw_m,
                                         input logic [4:0] wr_m,
                                         input logic       rw_w,
                                         input logic [4:0] wr_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != REG_ZERO && rw_m && wr_m == src)      sel = FWD_MEM;
    else if (src != REG_ZERO && rw_w && wr_w == src) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The pipeline is the master (drives
// register ids and stage flags); the hazard unit is the slave.
interface hazard_ctrl_if;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic       BranchD;
  logic       MdStartE;
  logic       StallF, StallD, FlushE;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MdBusy, MdDone;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartE,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy, MdDone
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartE,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy, MdDone
  );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Mul/div occupancy sequencer: start cycle, MD_LATENCY-2 busy cycles, one
// done cycle. Front end stalls on start and busy cycles, releases on done.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MdStartE_i,
  output logic MdBusy_o,
  output logic MdDone_o,
  output logic mdstall_o
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MD_LATENCY - 2);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic             start;

  // Reset gating keeps the start-cycle stall quiet while reset is held.
  assign start = (state_q == MD_IDLE) && MdStartE_i && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: if (MdStartE_i) begin
          cnt_q  <= LOAD;
          busy_q <= 1'b1;
          if (LOAD == '0) begin
            state_q <= MD_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Counter holds the busy cycles still to run, this one included.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_DONE;
            done_q  <= 1'b1;
          end
        end
        MD_DONE: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MdBusy_o  = busy_q | start;
  assign MdDone_o  = done_q;
  assign mdstall_o = start | (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use / branch-data stalls, and mul/div front-end freeze.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  logic lwstall, brstall, mdstall, stall;
  logic br_dep_e, br_dep_m;

  md_sequencer #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) u_md (
    .clk       (clk),
    .reset     (reset),
    .MdStartE_i(hz.MdStartE),
    .MdBusy_o  (hz.MdBusy),
    .MdDone_o  (hz.MdDone),
    .mdstall_o (mdstall)
  );

  assign hz.ForwardAE = fwd_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM,
                                hz.RegWriteW, hz.WriteRegW);
  assign hz.ForwardBE = fwd_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM,
                                hz.RegWriteW, hz.WriteRegW);

  assign hz.ForwardAD = (hz.RsD != REG_ZERO) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
  assign hz.ForwardBD = (hz.RtD != REG_ZERO) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);

  assign lwstall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

  // Branch compares in Decode: an ALU result still in Execute, or a load
  // still in Memory, is not yet forwardable to the comparator.
  assign br_dep_e = hz.RegWriteE && (hz.WriteRegE != REG_ZERO) &&
                    ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD));
  assign br_dep_m = hz.MemtoRegM && (hz.WriteRegM != REG_ZERO) &&
                    ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD));
  assign brstall  = hz.BranchD && (br_dep_e || br_dep_m);

  assign stall     = lwstall | brstall | mdstall;
  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan cases plus random
// stimulus against an occupancy-position reference model.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hif)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pos    = 0;  // 0 = unit free, k = k-th cycle of the current op

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic zero_in();
    hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
    hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
    hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.MemtoRegE = 0; hif.MemtoRegM = 0; hif.BranchD = 0; hif.MdStartE = 0;
  endtask

  function automatic int pos_now();
    if (reset) return 0;
    if (pos == 0 && hif.MdStartE) return 1;
    return pos;
  endfunction

  function automatic int fwd_exp(input logic [4:0] src);
    if (src != 0 && hif.RegWriteM && hif.WriteRegM == src) return 2;
    if (src != 0 && hif.RegWriteW && hif.WriteRegW == src) return 1;
    return 0;
  endfunction

  task automatic check_model(input string tag);
    int  p;
    bit  lw, br, md, st;
    p  = pos_now();
    md = (p >= 1) && (p < LAT);
    lw = hif.MemtoRegE && (hif.RtE == hif.RsD || hif.RtE == hif.RtD);
    br = hif.BranchD &&
         ((hif.RegWriteE && hif.WriteRegE != 0 &&
           (hif.WriteRegE == hif.RsD || hif.WriteRegE == hif.RtD)) ||
          (hif.MemtoRegM && hif.WriteRegM != 0 &&
           (hif.WriteRegM == hif.RsD || hif.WriteRegM == hif.RtD)));
    st = lw || br || md;
    chk({tag, ".FAE"},    int'(hif.ForwardAE), fwd_exp(hif.RsE));
    chk({tag, ".FBE"},    int'(hif.ForwardBE), fwd_exp(hif.RtE));
    chk({tag, ".FAD"},    int'(hif.ForwardAD),
        int'(hif.RsD != 0 && hif.RegWriteM && hif.WriteRegM == hif.RsD));
    chk({tag, ".FBD"},    int'(hif.ForwardBD),
        int'(hif.RtD != 0 && hif.RegWriteM && hif.WriteRegM == hif.RtD));
    chk({tag, ".StallF"}, int'(hif.StallF), int'(st));
    chk({tag, ".StallD"}, int'(hif.StallD), int'(st));
    chk({tag, ".FlushE"}, int'(hif.FlushE), int'(st));
    chk({tag, ".MdBusy"}, int'(hif.MdBusy), int'(p >= 1));
    chk({tag, ".MdDone"}, int'(hif.MdDone), int'(p == LAT));
  endtask

  // Check at negedge, advance model at posedge, return just after the edge.
  task automatic step(input string tag);
    int p;
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    p   = pos_now();
    pos = (p == 0 || p == LAT) ? 0 : p + 1;
    #1;
  endtask

  // Full mul/div sequence from a one-cycle start pulse, plus one idle cycle.
  task automatic md_seq(input string tag);
    hif.MdStartE = 1;
    for (int c = 1; c <= LAT + 1; c++) begin
      #1;
      chk($sformatf("%s.stall%0d", tag, c), int'(hif.StallF), int'(c <= LAT - 1));
      chk($sformatf("%s.busy%0d", tag, c),  int'(hif.MdBusy), int'(c <= LAT));
      chk($sformatf("%s.done%0d", tag, c),  int'(hif.MdDone), int'(c == LAT));
      step(tag);
      hif.MdStartE = 0;
    end
  endtask

  initial begin
    zero_in();
    reset = 1;
    #12;
    chk("rst.MdBusy", int'(hif.MdBusy), 0);
    chk("rst.MdDone", int'(hif.MdDone), 0);
    chk("rst.StallF", int'(hif.StallF), 0);
    chk("rst.FlushE", int'(hif.FlushE), 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Forwarding priority and $0 exclusion
    hif.RsE = 5; hif.WriteRegM = 5; hif.RegWriteM = 1; hif.WriteRegW = 5; hif.RegWriteW = 1;
    #1 chk("fwd.mem", int'(hif.ForwardAE), 2);
    step("fwd1");
    hif.RegWriteM = 0;
    #1 chk("fwd.wb", int'(hif.ForwardAE), 1);
    step("fwd2");
    hif.RsE = 0; hif.RegWriteM = 1; hif.WriteRegM = 0; hif.WriteRegW = 0;
    #1 chk("fwd.zero", int'(hif.ForwardAE), 0);
    step("fwd3");
    zero_in();

    // Load-use
    hif.MemtoRegE = 1; hif.RtE = 8; hif.RsD = 8;
    #1 chk("lw.StallF", int'(hif.StallF), 1);
    chk("lw.FlushE", int'(hif.FlushE), 1);
    step("lw1");
    hif.MemtoRegE = 0;
    #1 chk("lw.release", int'(hif.StallD), 0);
    step("lw2");
    zero_in();

    // Branch data hazard, then forwarding to the comparator
    hif.BranchD = 1; hif.RsD = 3; hif.RegWriteE = 1; hif.WriteRegE = 3;
    #1 chk("br.stall", int'(hif.StallD), 1);
    step("br1");
    hif.RegWriteE = 0; hif.WriteRegE = 0;
    hif.WriteRegM = 3; hif.MemtoRegM = 0; hif.RegWriteM = 1;
    #1 chk("br.release", int'(hif.StallF), 0);
    chk("br.FAD", int'(hif.ForwardAD), 1);
    step("br2");
    zero_in();

    md_seq("md");

    // Async reset during BUSY aborts with no done pulse
    hif.MdStartE = 1;
    step("ab1");
    hif.MdStartE = 0;
    step("ab2");
    #2 reset = 1;
    #1;
    chk("ab.MdBusy", int'(hif.MdBusy), 0);
    chk("ab.StallF", int'(hif.StallF), 0);
    chk("ab.MdDone", int'(hif.MdDone), 0);
    pos = 0;
    for (int i = 0; i < 3; i++) step("abr");
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    md_seq("md2");

    // Mul/div start coincident with a load-use held for 5 cycles
    hif.MdStartE = 1; hif.MemtoRegE = 1; hif.RtE = 8; hif.RsD = 8;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) hif.MemtoRegE = 0;
      #1;
      chk($sformatf("co.stall%0d", c), int'(hif.StallF), int'(c <= 5));
      chk($sformatf("co.done%0d", c),  int'(hif.MdDone), int'(c == LAT));
      step("co");
      hif.MdStartE = 0;
    end
    zero_in();

    // Random traffic on a small register range to force matches
    for (int i = 0; i < 400; i++) begin
      hif.RsD = 5'($urandom_range(0, 3)); hif.RtD = 5'($urandom_range(0, 3));
      hif.RsE = 5'($urandom_range(0, 3)); hif.RtE = 5'($urandom_range(0, 3));
      hif.WriteRegE = 5'($urandom_range(0, 3));
      hif.WriteRegM = 5'($urandom_range(0, 3));
      hif.WriteRegW = 5'($urandom_range(0, 3));
      hif.RegWriteE = 1'($urandom); hif.RegWriteM = 1'($urandom);
      hif.RegWriteW = 1'($urandom);
      hif.MemtoRegE = ($urandom_range(0, 3) == 0);
      hif.MemtoRegM = ($urandom_range(0, 3) == 0);
      hif.BranchD   = 1'($urandom);
      hif.MdStartE  = ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
